// File: rtl/instr_encoder_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_encoder_loader                                            |
// | Purpose  : Packs MIPS instruction-field commands into 32-bit words, streams |
// |            them into imem and holds the core in reset until loading ends.  |
// |            Optional macro NOP_PAD_EN fills the remaining words with NOPs.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module instr_encoder_loader #(
   parameter int ADDR_W    = 6,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              finish,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_kind,
   input  logic [4:0]        cmd_rs,
   input  logic [4:0]        cmd_rt,
   input  logic [4:0]        cmd_rd,
   input  logic [5:0]        cmd_funct,
   input  logic [15:0]       cmd_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              err_illegal,
   output logic              err_overflow
);

   localparam int              c_depth    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] c_cap      = (ADDR_W+1)'(c_depth - BASE_ADDR);
   localparam logic [ADDR_W-1:0] c_base   = ADDR_W'(BASE_ADDR);

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_PAD  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [ADDR_W:0] r_count;
   logic            r_fin;
   logic            w_full;
   logic            w_start;
   logic            w_accept;
   logic            w_legal;
   logic            w_pad_wr;
   logic [5:0]      w_op;
   logic [31:0]     w_enc;

   assign w_full    = (r_count >= c_cap);
   assign w_start   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_accept  = cmd_valid && cmd_ready;
   assign cpu_hold  = (r_state != S_DONE);
   assign load_done = (r_state == S_DONE);

   always_comb begin
      w_legal = 1'b1;
      w_op    = c_op_rtype;
      case (cmd_kind)
         3'd0:    w_op = c_op_rtype;
         3'd1:    w_op = c_op_addi;
         3'd2:    w_op = c_op_beq;
         3'd3:    w_op = c_op_lw;
         3'd4:    w_op = c_op_sw;
         default: w_legal = 1'b0;
      endcase
      if (cmd_kind == 3'd0) begin
         w_enc = {w_op, cmd_rs, cmd_rt, cmd_rd, 5'd0, cmd_funct};
      end else begin
         w_enc = {w_op, cmd_rs, cmd_rt, cmd_imm};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Once finish is latched, LOAD lingers one cycle so the final accepted
   // word is on the bus before the core is released or padding begins.
   always_comb begin
      w_next    = r_state;
      cmd_ready = 1'b0;
      w_pad_wr  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next = S_LOAD;
         end
         S_LOAD: begin
            cmd_ready = !r_fin && !w_full;
            if (r_fin) begin
`ifdef NOP_PAD_EN
               w_next = S_PAD;
`else
               w_next = S_DONE;
`endif
            end
         end
         S_PAD: begin
`ifdef NOP_PAD_EN
            w_pad_wr = !w_full;
            if (w_full && !imem_we) w_next = S_DONE;
`else
            w_next = S_DONE;
`endif
         end
         S_DONE: begin
            if (start) w_next = S_LOAD;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count      <= '0;
         r_fin        <= 1'b0;
         imem_we      <= 1'b0;
         imem_waddr   <= '0;
         imem_wdata   <= '0;
         err_illegal  <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (w_start) begin
            r_count      <= '0;
            r_fin        <= 1'b0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
         end else begin
            if ((r_state == S_LOAD) && !r_fin) begin
               if (finish) r_fin <= 1'b1;
               if (cmd_valid && w_full) err_overflow <= 1'b1;
            end
            if (w_accept) begin
               if (w_legal) begin
                  imem_we    <= 1'b1;
                  imem_waddr <= c_base + r_count[ADDR_W-1:0];
                  imem_wdata <= w_enc;
                  r_count    <= r_count + 1'b1;
               end else begin
                  err_illegal <= 1'b1;
               end
            end
            if (w_pad_wr) begin
               imem_we    <= 1'b1;
               imem_waddr <= c_base + r_count[ADDR_W-1:0];
               imem_wdata <= 32'h0000_0000;
               r_count    <= r_count + 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire
